// File: rtl/ppu_sprite_eval_pkg.sv
// Shared types and dot/line constants for the per-scanline sprite evaluation stage.
package ppu_sprite_eval_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StCopy,
        StOvf,
        StDone
    } eval_state_e;

    localparam int unsigned OamAddrW        = 8;
    localparam int unsigned SecAddrW        = 5;
    localparam int unsigned DotClearEnd     = 64;
    localparam int unsigned DotEvalEnd      = 256;
    localparam int unsigned DotFetchStart   = 257;
    localparam int unsigned LineLastVisible = 239;
    localparam int unsigned LinePrerender   = 261;
    localparam logic [7:0]  SecOamFill      = 8'hFF;

endpackage

// File: rtl/ppu_sprite_eval_if.sv
// Dot timing, primary OAM read port, secondary OAM write port and status of sprite evaluation.
interface ppu_sprite_eval_if;
    import ppu_sprite_eval_pkg::*;

    logic [8:0]          x_i;
    logic [8:0]          y_i;
    logic                rendering_en_i;
    logic                sprite_size16_i;
    logic [OamAddrW-1:0] oam_addr_o;
    logic [7:0]          oam_data_i;
    logic [SecAddrW-1:0] sec_oam_addr_o;
    logic [7:0]          sec_oam_wdata_o;
    logic                sec_oam_we_o;
    logic                sprite_overflow_o;
    logic                sprite0_hit_line_o;
    logic [3:0]          sprite_count_o;

    modport master (
        output x_i, y_i, rendering_en_i, sprite_size16_i, oam_data_i,
        input  oam_addr_o, sec_oam_addr_o, sec_oam_wdata_o, sec_oam_we_o,
        input  sprite_overflow_o, sprite0_hit_line_o, sprite_count_o
    );

    modport slave (
        input  x_i, y_i, rendering_en_i, sprite_size16_i, oam_data_i,
        output oam_addr_o, sec_oam_addr_o, sec_oam_wdata_o, sec_oam_we_o,
        output sprite_overflow_o, sprite0_hit_line_o, sprite_count_o
    );

endinterface

// File: rtl/ppu_sprite_eval_in_range.sv
// Sprite vertical range test; also used by the fetch stage for row-offset selection.
module ppu_sprite_eval_in_range (
    input  logic [8:0] y,
    input  logic [7:0] spr_y,
    input  logic       size16,
    output logic       hit
);
    logic [8:0] diff;

    // Unsigned wrap makes sprites below the current line look far away.
    assign diff = y - {1'b0, spr_y};
    assign hit  = size16 ? (diff < 9'd16) : (diff < 9'd8);

endmodule

// File: rtl/ppu_sprite_eval.sv
// Clears secondary OAM, scans primary OAM for up to eight in-range sprites and raises
// the overflow flag with the original diagonal-scan behaviour.
module ppu_sprite_eval
    import ppu_sprite_eval_pkg::*;
#(
    parameter int unsigned NumSprites = 64,
    parameter int unsigned SecSlots   = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    ppu_sprite_eval_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(NumSprites);
    localparam int unsigned SlotW = $clog2(SecSlots);

    eval_state_e      state_q, state_d;
    logic [IdxW-1:0]  n_q, n_d;
    logic [1:0]       m_q, m_d;
    logic [SlotW:0]   s_q, s_d;
    logic [7:0]       rd_buf_q;
    logic             s0_next_q, s0_next_d;
    logic             ovf_q, ovf_d;
    logic             s0_hit_q, s0_hit_d;
    logic [3:0]       count_q, count_d;

    logic             active, eval_dot, hit, n_last;
    logic             we;
    logic [SlotW+1:0] waddr;
    logic [7:0]       wdata;

    assign active   = bus.rendering_en_i && (bus.y_i <= 9'(LineLastVisible));
    assign eval_dot = ~bus.x_i[0] && (bus.x_i >= 9'd2) && (bus.x_i <= 9'(DotEvalEnd));
    assign n_last   = (n_q == IdxW'(NumSprites - 1));

    ppu_sprite_eval_in_range u_in_range (
        .y      (bus.y_i),
        .spr_y  (rd_buf_q),
        .size16 (bus.sprite_size16_i),
        .hit    (hit)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        m_d       = m_q;
        s_d       = s_q;
        s0_next_d = s0_next_q;
        ovf_d     = ovf_q;
        s0_hit_d  = s0_hit_q;
        count_d   = count_q;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;

        if (!active) begin
            state_d = StIdle;
        end else if (bus.x_i == 9'd1) begin
            state_d   = StClear;
            s0_next_d = 1'b0;
        end else if (eval_dot) begin
            case (state_q)
                StClear: begin
                    we    = 1'b1;
                    waddr = bus.x_i[SlotW+2:1] - 1'b1;
                    wdata = SecOamFill;
                    if (bus.x_i == 9'(DotClearEnd)) begin
                        state_d = StScan;
                        n_d     = '0;
                        m_d     = '0;
                        s_d     = '0;
                    end
                end
                StScan: begin
                    // Y byte lands in the next free slot even when the sprite misses.
                    we    = 1'b1;
                    waddr = {s_q[SlotW-1:0], 2'b00};
                    wdata = rd_buf_q;
                    if (hit) begin
                        if (n_q == '0) s0_next_d = 1'b1;
                        m_d     = 2'd1;
                        state_d = StCopy;
                    end else begin
                        n_d = n_q + 1'b1;
                        if (n_last) state_d = StDone;
                    end
                end
                StCopy: begin
                    we    = 1'b1;
                    waddr = {s_q[SlotW-1:0], m_q};
                    wdata = rd_buf_q;
                    m_d   = m_q + 2'd1;
                    if (m_q == 2'd3) begin
                        s_d = s_q + 1'b1;
                        n_d = n_q + 1'b1;
                        if (n_last)                          state_d = StDone;
                        else if (s_d == (SlotW+1)'(SecSlots)) state_d = StOvf;
                        else                                 state_d = StScan;
                    end
                end
                StOvf: begin
                    if (hit) begin
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        // m advances with n: the original hardware's diagonal walk.
                        n_d = n_q + 1'b1;
                        m_d = m_q + 2'd1;
                        if (n_last) state_d = StDone;
                    end
                end
                default: ;
            endcase
        end

        if (active && (bus.x_i == 9'(DotFetchStart))) begin
            s0_hit_d = s0_next_q;
            count_d  = 4'(s_q);
        end

        if ((bus.y_i == 9'(LinePrerender)) && (bus.x_i == 9'd1)) begin
            ovf_d    = 1'b0;
            s0_hit_d = 1'b0;
        end

        if (rst_i) begin
            we    = 1'b0;
            waddr = '0;
            wdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            n_q       <= '0;
            m_q       <= '0;
            s_q       <= '0;
            rd_buf_q  <= '0;
            s0_next_q <= 1'b0;
            ovf_q     <= 1'b0;
            s0_hit_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            m_q       <= m_d;
            s_q       <= s_d;
            s0_next_q <= s0_next_d;
            ovf_q     <= ovf_d;
            s0_hit_q  <= s0_hit_d;
            count_q   <= count_d;
            if (bus.x_i[0]) rd_buf_q <= bus.oam_data_i;
        end
    end

    assign bus.oam_addr_o         = {n_q, m_q};
    assign bus.sec_oam_we_o       = we;
    assign bus.sec_oam_addr_o     = waddr;
    assign bus.sec_oam_wdata_o    = wdata;
    assign bus.sprite_overflow_o  = ovf_q;
    assign bus.sprite0_hit_line_o = s0_hit_q;
    assign bus.sprite_count_o     = count_q;

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Self-checking bench: drives whole scanlines against a byte-array OAM and checks writes/flags.
module tb_ppu_sprite_eval;

    typedef logic [12:0] exp_t;  // {sec addr, byte}

    logic clk;
    logic rst;
    logic [7:0] oam [256];
    logic [7:0] sec_mem [32];
    exp_t clr_q[$];
    exp_t slot_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int clr_seen = 0;
    bit clr_chk = 0;

    ppu_sprite_eval_if bus ();

    ppu_sprite_eval dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.oam_data_i = oam[bus.oam_addr_o];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write monitor: shadows secondary OAM, checks the write window and the clear sequence.
    always @(negedge clk) begin
        if (bus.sec_oam_we_o === 1'b1) begin
            wr_count++;
            sec_mem[bus.sec_oam_addr_o] = bus.sec_oam_wdata_o;
            checks++;
            if (rst || bus.x_i < 9'd2 || bus.x_i > 9'd256 || bus.x_i[0]) begin
                errors++;
                $display("FAIL write_window: write at dot %0d, required even dot 2..256", bus.x_i);
            end
            if (clr_chk && bus.x_i <= 9'd64) begin
                clr_seen++;
                checks++;
                if (clr_q.size() == 0) begin
                    errors++;
                    $display("FAIL clear_extra: write addr %0d at dot %0d, none required",
                             bus.sec_oam_addr_o, bus.x_i);
                end else begin
                    mon_e = clr_q.pop_front();
                    if ({bus.sec_oam_addr_o, bus.sec_oam_wdata_o} !== mon_e) begin
                        errors++;
                        $display("FAIL clear_write: got addr %0d data %02h, required addr %0d data %02h",
                                 bus.sec_oam_addr_o, bus.sec_oam_wdata_o, mon_e[12:8], mon_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic run_dots(input int yy, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            bus.x_i = 9'(x);
            bus.y_i = 9'(yy);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_line(input int yy);
        run_dots(yy, 0, 340);
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 256; i++) oam[i] = v;
    endtask

    task automatic set_sprite(input int n, input logic [7:0] yv);
        oam[4*n]   = yv;
        oam[4*n+1] = 8'(n + 1);
        oam[4*n+2] = 8'(n + 2);
        oam[4*n+3] = 8'(n + 3);
    endtask

    task automatic push_slot(input int slot, input int n);
        for (int b = 0; b < 4; b++) slot_q.push_back({5'(slot*4 + b), oam[4*n+b]});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        run_dots(0, 0, 2);
        rst = 1'b0;
        checks++;
        if ({bus.sprite_count_o, bus.sprite_overflow_o, bus.sprite0_hit_line_o} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags: got cnt %0d ovf %0b s0 %0b, required 0 0 0",
                     bus.sprite_count_o, bus.sprite_overflow_o, bus.sprite0_hit_line_o);
        end
        checks++;
        if ({bus.sec_oam_we_o, bus.oam_addr_o, bus.sec_oam_addr_o, bus.sec_oam_wdata_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_bus: got we %0b oam %0h sec %0h wd %0h, required all 0",
                     bus.sec_oam_we_o, bus.oam_addr_o, bus.sec_oam_addr_o, bus.sec_oam_wdata_o);
        end
    endtask

    task automatic test_clear;
        set_all(8'hF0);
        for (int i = 0; i < 32; i++) clr_q.push_back({5'(i), 8'hFF});
        clr_seen = 0;
        clr_chk = 1'b1;
        run_line(5);
        clr_chk = 1'b0;
        checks++;
        if (clr_seen != 32 || clr_q.size() != 0) begin
            errors++;
            $display("FAIL clear_count: got %0d writes (%0d left), required 32",
                     clr_seen, clr_q.size());
        end
        checks++;
        if (bus.sprite_count_o !== 4'd0) begin
            errors++;
            $display("FAIL clear_scan_count: got %0d required 0", bus.sprite_count_o);
        end
    endtask

    task automatic test_basic_copy;
        exp_t e;
        set_all(8'hF0);
        set_sprite(0, 8'd10);
        set_sprite(5, 8'd10);
        set_sprite(63, 8'd10);
        push_slot(0, 0);
        push_slot(1, 5);
        push_slot(2, 63);
        run_line(12);
        while (slot_q.size() > 0) begin
            e = slot_q.pop_front();
            checks++;
            if (sec_mem[e[12:8]] !== e[7:0]) begin
                errors++;
                $display("FAIL basic_slot addr %0d: got %02h required %02h",
                         e[12:8], sec_mem[e[12:8]], e[7:0]);
            end
        end
        checks++;
        if ({bus.sprite_count_o, bus.sprite0_hit_line_o, bus.sprite_overflow_o} !== {4'd3, 2'b10}) begin
            errors++;
            $display("FAIL basic_flags: got cnt %0d s0 %0b ovf %0b, required 3 1 0",
                     bus.sprite_count_o, bus.sprite0_hit_line_o, bus.sprite_overflow_o);
        end
    endtask

    task automatic test_size_boundary;
        int ys [4] = '{25, 26, 17, 18};
        bit big [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int want [4] = '{1, 0, 1, 0};
        set_all(8'hF0);
        set_sprite(0, 8'd10);
        for (int i = 0; i < 4; i++) begin
            bus.sprite_size16_i = big[i];
            run_line(ys[i]);
            checks++;
            if (bus.sprite_count_o !== 4'(want[i]) || bus.sprite0_hit_line_o !== 1'(want[i])) begin
                errors++;
                $display("FAIL size_boundary y=%0d size16=%0b: got cnt %0d s0 %0b, required %0d",
                         ys[i], big[i], bus.sprite_count_o, bus.sprite0_hit_line_o, want[i]);
            end
        end
        bus.sprite_size16_i = 1'b0;
    endtask

    task automatic test_overflow;
        exp_t e;
        set_all(8'hF0);
        for (int n = 0; n <= 8; n++) set_sprite(n, 8'd20);
        for (int n = 0; n < 8; n++) push_slot(n, n);
        run_dots(20, 0, 256);
        checks++;
        if (bus.sprite_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_by_256: got %0b required 1", bus.sprite_overflow_o);
        end
        run_dots(20, 257, 340);
        while (slot_q.size() > 0) begin
            e = slot_q.pop_front();
            checks++;
            if (sec_mem[e[12:8]] !== e[7:0]) begin
                errors++;
                $display("FAIL overflow_slot addr %0d: got %02h required %02h",
                         e[12:8], sec_mem[e[12:8]], e[7:0]);
            end
        end
        checks++;
        if (bus.sprite_count_o !== 4'd8) begin
            errors++;
            $display("FAIL overflow_count: got %0d required 8", bus.sprite_count_o);
        end
        run_dots(261, 0, 0);
        checks++;
        if (bus.sprite_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold_dot0: got %0b required 1", bus.sprite_overflow_o);
        end
        run_dots(261, 1, 1);
        checks++;
        if (bus.sprite_overflow_o !== 1'b0 || bus.sprite0_hit_line_o !== 1'b0) begin
            errors++;
            $display("FAIL prerender_clear: got ovf %0b s0 %0b required 0 0",
                     bus.sprite_overflow_o, bus.sprite0_hit_line_o);
        end
        run_dots(261, 2, 340);
    endtask

    task automatic test_overflow_bug;
        set_all(8'hF0);
        for (int n = 0; n < 8; n++) set_sprite(n, 8'd20);
        oam[4*9+1] = 8'd20;
        run_line(20);
        checks++;
        if (bus.sprite_overflow_o !== 1'b1 || bus.sprite_count_o !== 4'd8) begin
            errors++;
            $display("FAIL bug_false_positive: got ovf %0b cnt %0d required 1 8",
                     bus.sprite_overflow_o, bus.sprite_count_o);
        end
        run_line(261);
        oam[4*9+1] = 8'hF0;
        run_line(20);
        checks++;
        if (bus.sprite_overflow_o !== 1'b0 || bus.sprite_count_o !== 4'd8) begin
            errors++;
            $display("FAIL bug_no_overflow: got ovf %0b cnt %0d required 0 8",
                     bus.sprite_overflow_o, bus.sprite_count_o);
        end
    endtask

    task automatic test_disable_reset;
        exp_t e;
        set_all(8'hF0);
        set_sprite(0, 8'd10);
        set_sprite(5, 8'd10);
        set_sprite(63, 8'd10);
        run_line(12);
        bus.rendering_en_i = 1'b0;
        wr_count = 0;
        run_line(12);
        bus.rendering_en_i = 1'b1;
        checks++;
        if (wr_count != 0 || bus.sprite_count_o !== 4'd3 || bus.sprite0_hit_line_o !== 1'b1) begin
            errors++;
            $display("FAIL disabled_line: got %0d writes cnt %0d s0 %0b, required 0 3 1",
                     wr_count, bus.sprite_count_o, bus.sprite0_hit_line_o);
        end
        run_dots(12, 0, 149);
        rst = 1'b1;
        run_dots(12, 150, 150);
        checks++;
        if ({bus.sprite_count_o, bus.sprite0_hit_line_o, bus.sprite_overflow_o, bus.sec_oam_we_o,
             bus.oam_addr_o} !== 15'd0) begin
            errors++;
            $display("FAIL midline_reset: got cnt %0d s0 %0b ovf %0b we %0b oam %0h, required 0",
                     bus.sprite_count_o, bus.sprite0_hit_line_o, bus.sprite_overflow_o,
                     bus.sec_oam_we_o, bus.oam_addr_o);
        end
        rst = 1'b0;
        run_dots(12, 151, 340);
        checks++;
        if (bus.sprite_count_o !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_count: got %0d required 0", bus.sprite_count_o);
        end
        push_slot(0, 0);
        push_slot(1, 5);
        push_slot(2, 63);
        run_line(13);
        while (slot_q.size() > 0) begin
            e = slot_q.pop_front();
            checks++;
            if (sec_mem[e[12:8]] !== e[7:0]) begin
                errors++;
                $display("FAIL recover_slot addr %0d: got %02h required %02h",
                         e[12:8], sec_mem[e[12:8]], e[7:0]);
            end
        end
        checks++;
        if (bus.sprite_count_o !== 4'd3 || bus.sprite0_hit_line_o !== 1'b1) begin
            errors++;
            $display("FAIL recover_flags: got cnt %0d s0 %0b required 3 1",
                     bus.sprite_count_o, bus.sprite0_hit_line_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.x_i = '0;
        bus.y_i = '0;
        bus.rendering_en_i = 1'b1;
        bus.sprite_size16_i = 1'b0;
        for (int i = 0; i < 32; i++) sec_mem[i] = 8'h00;
        set_all(8'hF0);
        @(posedge clk);
        #1;
        test_reset();
        test_clear();
        test_basic_copy();
        test_size_boundary();
        test_overflow();
        test_overflow_bug();
        test_disable_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
